// File: rtl/l3_pkg.sv
// Shared types and helpers for the multi-port shared L3 backing model.
package l3_pkg;

    localparam int L3_DATA_W = 64;

    // One response entry: write flag on top, read data below.
    typedef struct packed {
        logic                 write;
        logic [L3_DATA_W-1:0] rdata;
    } l3_resp_t;

    // Number of byte-offset bits inside one word.
    function automatic int l3_off_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    // Number of word-index bits for the array.
    function automatic int l3_idx_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/l3_resp_fifo.sv
// Per-port response FIFO with registered occupancy count and flags.
// Output data reads as zero while the FIFO is empty.
module l3_resp_fifo
    import l3_pkg::*;
#(
    parameter int RESP_DEPTH = 4,
    parameter int W          = $bits(l3_resp_t)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic [W-1:0]                push_data,
    input  logic                        pop,
    output logic [W-1:0]                pop_data,
    output logic [$clog2(RESP_DEPTH):0] count,
    output logic                        empty,
    output logic                        full
);

    localparam int PTR_W = $clog2(RESP_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     store [RESP_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;

    // Entry storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            store[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop keep the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign count    = cnt;
    assign empty    = (cnt == '0);
    assign full     = (cnt == CNT_W'(RESP_DEPTH));
    assign pop_data = empty ? '0 : store[rd_ptr];

endmodule

// File: rtl/l3_shared_mem_mp.sv
// Multi-port shared L3 backing model: round-robin arbiter, shared word array,
// fixed-latency read pipeline and credit-protected per-port response FIFOs.
// Optional macro L3_PERF_CNT_EN enables the grant/stall performance counters.
//
// Handshake: a request is accepted on a clock edge where req_valid_i[p] and
// req_ready_o[p] are both high; a response is consumed on an edge where
// resp_valid_o[p] and resp_ready_i[p] are both high. Valid must not depend on
// ready on either side.
module l3_shared_mem_mp
    import l3_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_W     = 64,
    parameter int DEPTH      = 4096,
    parameter int LATENCY    = 2,
    parameter int RESP_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_PORTS-1:0]             req_valid_i,
    output logic [NUM_PORTS-1:0]             req_ready_o,
    input  logic [NUM_PORTS-1:0][63:0]       req_addr_i,
    input  logic [NUM_PORTS-1:0]             req_write_i,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0] req_wdata_i,
    input  logic [NUM_PORTS-1:0][DATA_W/8-1:0] req_be_i,
    output logic [NUM_PORTS-1:0]             resp_valid_o,
    input  logic [NUM_PORTS-1:0]             resp_ready_i,
    output logic [NUM_PORTS-1:0][DATA_W-1:0] resp_rdata_o,
    output logic [NUM_PORTS-1:0]             resp_write_o,
    output logic [31:0]                      perf_grants_o,
    output logic [31:0]                      perf_stalls_o
);

    localparam int OFF    = l3_off_w(DATA_W);
    localparam int IDX_W  = l3_idx_w(DEPTH);
    localparam int BE_W   = DATA_W / 8;
    localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int PW1    = PORT_W + 1;
    localparam int CNT_W  = $clog2(RESP_DEPTH) + 1;
    localparam int SUM_W  = CNT_W + 1;
    localparam int RESP_W = DATA_W + 1;

    logic [DATA_W-1:0]    mem [DEPTH];

    logic [NUM_PORTS-1:0] eligible;
    logic [NUM_PORTS-1:0] grant;
    logic [PORT_W-1:0]    grant_port;
    logic                 found;
    logic [PW1-1:0]       cand_w;
    logic [PORT_W-1:0]    cand;
    logic [PORT_W-1:0]    rr_ptr;
    logic                 acc;

    logic [63:0]          sel_addr;
    logic                 sel_write;
    logic [DATA_W-1:0]    sel_wdata;
    logic [BE_W-1:0]      sel_be;
    logic [IDX_W-1:0]     idx;
    logic                 addr_unused;

    logic [LATENCY-1:0]   pv;
    logic [PORT_W-1:0]    pp [LATENCY];
    logic [RESP_W-1:0]    pr [LATENCY];

    logic [CNT_W-1:0]     inflight   [NUM_PORTS];
    logic [CNT_W-1:0]     fifo_count [NUM_PORTS];
    logic [RESP_W-1:0]    fifo_out   [NUM_PORTS];
    logic [NUM_PORTS-1:0] fifo_empty;
    logic [NUM_PORTS-1:0] fifo_full;
    logic [NUM_PORTS-1:0] push;
    logic [NUM_PORTS-1:0] pop;

    // A port may compete only while its outstanding responses fit its FIFO.
    always_comb begin
        eligible = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            eligible[p] = req_valid_i[p] && !fifo_full[p] &&
                (({1'b0, inflight[p]} + {1'b0, fifo_count[p]}) < SUM_W'(RESP_DEPTH));
        end
    end

    // Round-robin pick: first eligible port at or after rr_ptr.
    always_comb begin
        grant      = '0;
        grant_port = '0;
        found      = 1'b0;
        cand_w     = '0;
        cand       = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand_w = {1'b0, rr_ptr} + PW1'(i);
            if (cand_w >= PW1'(NUM_PORTS)) cand_w = cand_w - PW1'(NUM_PORTS);
            cand = cand_w[PORT_W-1:0];
            if (!found && eligible[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_port  = cand;
            end
        end
    end

    assign req_ready_o = grant;
    assign acc         = |grant;
    assign sel_addr    = req_addr_i[grant_port];
    assign sel_write   = req_write_i[grant_port];
    assign sel_wdata   = req_wdata_i[grant_port];
    assign sel_be      = req_be_i[grant_port];
    assign idx         = sel_addr[OFF +: IDX_W];
    // Bits outside the word index are deliberately ignored (aliasing).
    assign addr_unused = ^sel_addr;

    // Round-robin pointer advances past the granted port, holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (acc) begin
            rr_ptr <= (grant_port == PORT_W'(NUM_PORTS - 1)) ? '0 : grant_port + PORT_W'(1);
        end
    end

    // Byte-enable write into the array at the accept edge.
    always_ff @(posedge clk) begin
        if (acc && sel_write) begin
            for (int b = 0; b < BE_W; b++) begin
                if (sel_be[b]) mem[idx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
            end
        end
    end

    // Array read register followed by LATENCY-1 delay stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                pp[k] <= '0;
                pr[k] <= '0;
            end
        end else begin
            pv[0] <= acc;
            pp[0] <= grant_port;
            pr[0] <= sel_write ? {1'b1, {DATA_W{1'b0}}} : {1'b0, mem[idx]};
            for (int k = 1; k < LATENCY; k++) begin
                pv[k] <= pv[k-1];
                pp[k] <= pp[k-1];
                pr[k] <= pr[k-1];
            end
        end
    end

    // Outstanding count per port: granted but not yet pushed into its FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NUM_PORTS; p++) inflight[p] <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                case ({grant[p], push[p]})
                    2'b10:   inflight[p] <= inflight[p] + CNT_W'(1);
                    2'b01:   inflight[p] <= inflight[p] - CNT_W'(1);
                    default: inflight[p] <= inflight[p];
                endcase
            end
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign push[p] = pv[LATENCY-1] && (pp[LATENCY-1] == PORT_W'(p));
        assign pop[p]  = resp_valid_o[p] && resp_ready_i[p];

        l3_resp_fifo #(
            .RESP_DEPTH (RESP_DEPTH),
            .W          (RESP_W)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push[p]),
            .push_data (pr[LATENCY-1]),
            .pop       (pop[p]),
            .pop_data  (fifo_out[p]),
            .count     (fifo_count[p]),
            .empty     (fifo_empty[p]),
            .full      (fifo_full[p])
        );

        assign resp_valid_o[p] = !fifo_empty[p];
        assign resp_write_o[p] = fifo_out[p][DATA_W];
        assign resp_rdata_o[p] = fifo_out[p][DATA_W-1:0];
    end

`ifdef L3_PERF_CNT_EN
    logic [31:0] grants_q;
    logic [31:0] stalls_q;

    // Accepted requests and cycles with at least one refused valid request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grants_q <= '0;
            stalls_q <= '0;
        end else begin
            if (acc) grants_q <= grants_q + 32'd1;
            if (|(req_valid_i & ~grant)) stalls_q <= stalls_q + 32'd1;
        end
    end

    assign perf_grants_o = grants_q;
    assign perf_stalls_o = stalls_q;
`else
    assign perf_grants_o = '0;
    assign perf_stalls_o = '0;
`endif

endmodule

// File: doc/l3_shared_mem_mp.md
# l3_shared_mem_mp

Parametrised multi-port successor to the single-port shared L3 backing model. Serves NUM_PORTS requesters (L2 slices, DMA) from one shared word array through a round-robin arbiter, a fixed-latency read pipeline and per-port credit-protected response FIFOs, with byte-enable writes and valid/ready on both request and response sides. Sits between the L2 interconnect and the memory model; directory and coherence remain out of scope.

## Interface
- NUM_PORTS, 2: number of requester ports, 1..8.
- DATA_W, 64: word width in bits, a power of two, at least 8.
- DEPTH, 4096: words in the array, a power of two.
- LATENCY, 2: accept-to-response cycles, at least 1.
- RESP_DEPTH, 4: entries per port response FIFO, a power of two, at least 2.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid_i  in  NUM_PORTS  per-port request valid.
- req_ready_o  out  NUM_PORTS  per-port request accepted this cycle.
- req_addr_i  in  NUM_PORTS x 64  byte address.
- req_write_i  in  NUM_PORTS  1 = write, 0 = read.
- req_wdata_i  in  NUM_PORTS x DATA_W  write data.
- req_be_i  in  NUM_PORTS x DATA_W/8  write byte enables.
- resp_valid_o  out  NUM_PORTS  response available.
- resp_ready_i  in  NUM_PORTS  response consumed.
- resp_rdata_o  out  NUM_PORTS x DATA_W  read data. Writes return 0.
- resp_write_o  out  NUM_PORTS  response belongs to a write.
- perf_grants_o  out  32  total accepted requests.
- perf_stalls_o  out  32  cycles in which at least one valid request was not accepted.

## Operation
- Word index: req_addr_i[OFF +: log2(DEPTH)], where OFF = log2(DATA_W/8). Higher address bits are ignored (aliasing). Low offset bits are ignored.
- Eligibility: port p is eligible when req_valid_i[p] = 1 and inflight[p] + fifo_count[p] < RESP_DEPTH. inflight[p] counts accepted requests that have not yet reached the FIFO.
- Arbiter: at most one grant per cycle. Round-robin starts at rr_ptr. After a grant, rr_ptr moves to the granted port + 1, wrapping mod NUM_PORTS. If nothing is granted, rr_ptr holds.
- req_ready_o is the one-hot grant. It is combinational from req_valid_i and the credit state. A request is accepted when valid & ready.
- Write at acceptance: for each byte with req_be_i set, the memory byte is updated. All other bytes are unchanged. be = 0 still returns a write response.
- Read at acceptance: the array is read at the accept edge. Because requests are serialised, a read accepted one cycle after a write to the same word returns the new data.
- Pipeline: LATENCY-1 stages of {valid, port, write, data} after the array read. The last stage pushes into FIFO[port]. Credits guarantee the push never overflows.
- Response FIFO: each port's responses appear in acceptance order. Pop on resp_valid_o & resp_ready_i. A push and a pop in the same cycle leave the count unchanged.
- Memory contents are not reset.

## Timing
- Accept at edge T; response visible from cycle T+LATENCY when the FIFO is empty. Sustained throughput is one request per cycle across all ports.
- Credit release: a pop frees its credit for eligibility in the next cycle (registered count).
- Reset values: req_ready_o = 0, resp_valid_o = 0, resp_rdata_o = 0, resp_write_o = 0, perf counters = 0.
- Reset state: rr_ptr = 0; pipeline, inflight counters and FIFOs are all cleared.
- Reset mid-operation discards all in-flight requests and queued responses. No response is emitted for them.
- Perf counters wrap at 2^32.

## Configuration
- L3_PERF_CNT_EN defined: perf_grants_o and perf_stalls_o count as described above.
- L3_PERF_CNT_EN undefined: both outputs are tied to 0 and no counter flops are synthesised.

## Structure
- l3_pkg holds:
  - l3_resp_t, the packed struct {write, rdata};
  - the helper localparam functions for OFF and index width.
- Sub-module l3_resp_fifo: parametrised by RESP_DEPTH and the l3_resp_t width, with registered count and empty/full flags. It is instantiated once per port via generate.

## Test plan
- Port 0 writes 0xDEAD_BEEF_0123_4567 to 0x40, then reads 0x40 → read response 0xDEAD_BEEF_0123_4567 exactly LATENCY cycles after the read is accepted; the write response has resp_write_o = 1 and rdata 0.
- Both ports request continuously from reset → grants alternate p0, p1, p0, p1; perf_grants_o = 4 after four accepts; perf_stalls_o increments each of those cycles.
- Port 1 holds resp_ready_i = 0 and issues 6 reads → exactly 4 (RESP_DEPTH) are accepted, then req_ready_o[1] = 0. One pop allows the next accept one cycle later.
- Write 0xFFFF...FF to word 5, then write 0x0 with be = 0x0F → read of word 5 returns 0xFFFF_FFFF_0000_0000.
- rst_n pulsed low with 3 requests in flight → all resp_valid_o = 0 after reset, and no stale response ever appears.
- Address 0x40 and address 0x40 + DEPTH*8 alias → a write to one is returned by a read of the other.
